// File: rtl/systolic_pkg.sv
// Shared types and default widths for the systolic-array accumulate/bias path.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int P_BW  = 16;
    localparam int AK_BW = 20;
    localparam int B_BW  = 8;
    localparam int N_TAP = 9;

endpackage

// File: rtl/acc_lane.sv
// Single-lane signed accumulator with clear and add-enable.
// ACC_KERNEL_SAT_EN selects clamping adds instead of modulo-2^AK_BW wrap.
module acc_lane #(
    parameter int P_BW  = systolic_pkg::P_BW,
    parameter int AK_BW = systolic_pkg::AK_BW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    add_i,
    input  logic signed [P_BW-1:0]  psum_i,
    output logic signed [AK_BW-1:0] acc_o
);

    logic signed [AK_BW-1:0] acc_q, acc_d;

`ifdef ACC_KERNEL_SAT_EN
    // One guard bit: disagreement between the top two bits means the add left range.
    logic signed [AK_BW:0] sum;

    always_comb begin
        sum   = (AK_BW+1)'(acc_q) + (AK_BW+1)'(psum_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            if (sum[AK_BW] != sum[AK_BW-1])
                acc_d = sum[AK_BW] ? {1'b1, {(AK_BW-1){1'b0}}} : {1'b0, {(AK_BW-1){1'b1}}};
            else
                acc_d = sum[AK_BW-1:0];
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (add_i)
            acc_d = acc_q + AK_BW'(psum_i);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/acc_kernel.sv
// Three-lane kernel-window accumulator with latched bias and one-cycle result strobe.
// Optional ACC_KERNEL_SAT_EN makes each lane add saturate (see acc_lane).
module acc_kernel #(
    parameter int P_BW   = systolic_pkg::P_BW,
    parameter int AK_BW  = systolic_pkg::AK_BW,
    parameter int B_BW   = systolic_pkg::B_BW,
    parameter int N_TAP  = systolic_pkg::N_TAP,
    parameter int CNT_BW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [B_BW-1:0]  i_bias,
    input  logic             i_valid,
    input  logic [P_BW-1:0]  i_psum0,
    input  logic [P_BW-1:0]  i_psum1,
    input  logic [P_BW-1:0]  i_psum2,
    output logic             o_busy,
    output logic             o_valid,
    output logic [AK_BW-1:0] o_acc_kernel0,
    output logic [AK_BW-1:0] o_acc_kernel1,
    output logic [AK_BW-1:0] o_acc_kernel2,
    output logic [B_BW-1:0]  o_bias
);

    import systolic_pkg::*;

    localparam int NUM_LANES = 3;

    state_e              state_q, state_d;
    logic [CNT_BW-1:0]   cnt_q, cnt_d;
    logic [B_BW-1:0]     bias_q, bias_d;
    logic                start_acc;
    logic                tap_acc;

    logic [NUM_LANES-1:0][P_BW-1:0]  psum;
    logic [NUM_LANES-1:0][AK_BW-1:0] acc;

    assign psum = {i_psum2, i_psum1, i_psum0};

    // A new window may open from IDLE or directly out of OUT (no bubble).
    assign start_acc = i_start && (state_q == IDLE || state_q == OUT);
    assign tap_acc   = i_valid && (state_q == ACC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    bias_d  = i_bias;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (i_valid) begin
                    cnt_d = cnt_q + CNT_BW'(1);
                    if (cnt_q == CNT_BW'(N_TAP - 1))
                        state_d = OUT;
                end
            end
            OUT: begin
                if (i_start) begin
                    bias_d  = i_bias;
                    cnt_d   = '0;
                    state_d = ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        acc_lane #(
            .P_BW  (P_BW),
            .AK_BW (AK_BW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (start_acc),
            .add_i  (tap_acc),
            .psum_i (psum[k]),
            .acc_o  (acc[k])
        );
    end

    assign o_busy        = (state_q == ACC);
    assign o_valid       = (state_q == OUT);
    assign o_acc_kernel0 = acc[0];
    assign o_acc_kernel1 = acc[1];
    assign o_acc_kernel2 = acc[2];
    assign o_bias        = bias_q;

endmodule

// File: tb/tb_acc_kernel.sv
// Self-checking bench for acc_kernel: directed scenarios plus random windows vs a window-level model.
module tb_acc_kernel;

    localparam int P_BW  = 16;
    localparam int AK_BW = 20;
    localparam int B_BW  = 8;
    localparam int N_TAP = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic [B_BW-1:0]  i_bias = '0;
    logic             i_valid = 1'b0;
    logic [P_BW-1:0]  i_psum0 = '0, i_psum1 = '0, i_psum2 = '0;
    logic             o_busy, o_valid;
    logic [AK_BW-1:0] o_acc_kernel0, o_acc_kernel1, o_acc_kernel2;
    logic [B_BW-1:0]  o_bias;

    acc_kernel dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_bias(i_bias), .i_valid(i_valid),
        .i_psum0(i_psum0), .i_psum1(i_psum1), .i_psum2(i_psum2),
        .o_busy(o_busy), .o_valid(o_valid),
        .o_acc_kernel0(o_acc_kernel0), .o_acc_kernel1(o_acc_kernel1), .o_acc_kernel2(o_acc_kernel2),
        .o_bias(o_bias)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Window-level reference: is a window open, how many taps taken, result-presentation flag.
    bit      m_open, m_present;
    int      m_taps;
    longint  m_sum [3];
    int      m_bias;

    localparam longint FULL = longint'(1) << AK_BW;
    localparam longint HALF = longint'(1) << (AK_BW - 1);

    function automatic longint lane_add(input longint a, input longint p);
        longint s;
        s = a + p;
`ifdef ACC_KERNEL_SAT_EN
        if (s > HALF - 1) s = HALF - 1;
        if (s < -HALF)    s = -HALF;
`else
        s = s % FULL;
        if (s >= HALF)  s -= FULL;
        if (s < -HALF)  s += FULL;
`endif
        return s;
    endfunction

    function automatic logic [63:0] as_bits(input longint v);
        return 64'(v) & 64'(FULL - 1);
    endfunction

    task automatic model_edge(input bit st, input int b, input bit v, input longint p0, input longint p1, input longint p2);
        if (!rst_n) begin
            m_open = 0; m_present = 0; m_taps = 0; m_bias = 0;
            foreach (m_sum[k]) m_sum[k] = 0;
        end else if (m_open) begin
            if (v) begin
                m_sum[0] = lane_add(m_sum[0], p0);
                m_sum[1] = lane_add(m_sum[1], p1);
                m_sum[2] = lane_add(m_sum[2], p2);
                m_taps++;
                if (m_taps == N_TAP) begin
                    m_open = 0; m_present = 1;
                end
            end
        end else if (st) begin
            m_open = 1; m_present = 0; m_taps = 0; m_bias = b;
            foreach (m_sum[k]) m_sum[k] = 0;
        end else begin
            m_present = 0;
        end
    endtask

    task automatic cyc(input bit st, input int b, input bit v, input longint p0, input longint p1, input longint p2);
        logic [63:0] t0, t1, t2;
        t0 = 64'(p0); t1 = 64'(p1); t2 = 64'(p2);
        i_start = st; i_bias = b[B_BW-1:0]; i_valid = v;
        i_psum0 = t0[P_BW-1:0]; i_psum1 = t1[P_BW-1:0]; i_psum2 = t2[P_BW-1:0];
        @(posedge clk);
        model_edge(st, b, v, p0, p1, p2);
        #1;
        chk("valid", 64'(o_valid), 64'(m_present));
        chk("busy",  64'(o_busy),  64'(m_open));
        chk("k0",    64'(o_acc_kernel0), as_bits(m_sum[0]));
        chk("k1",    64'(o_acc_kernel1), as_bits(m_sum[1]));
        chk("k2",    64'(o_acc_kernel2), as_bits(m_sum[2]));
        chk("bias",  64'(o_bias), 64'(m_bias));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    function automatic longint rnd_psum();
        return longint'($urandom_range(65535)) - 32768;
    endfunction

    initial begin
        int strobes;

        // reset
        rst_n = 1'b0;
        idle(2);
        chk("rst_state_busy", 64'(o_busy), 64'd0);
        chk("rst_state_k0", 64'(o_acc_kernel0), 64'd0);
        rst_n = 1'b1;

        // reset in the middle of a window
        cyc(1, 8'h3C, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 11, -5, 7);
        rst_n = 1'b0;
        cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 0, 1, 1, 1, 1);
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 1, 2, 2, 2);
            strobes += int'(o_valid);
        end
        chk("rst_no_strobe", 64'(strobes), 64'd0);
        chk("rst_bias", 64'(o_bias), 64'd0);

        // basic window
        cyc(1, 8'h05, 0, 0, 0, 0);
        for (int i = 0; i < N_TAP; i++) cyc(0, 0, 1, 1, -2, 100);
        chk("basic_valid", 64'(o_valid), 64'd1);
        chk("basic_busy", 64'(o_busy), 64'd0);
        chk("basic_k0", 64'(o_acc_kernel0), 64'd9);
        chk("basic_k1", 64'(o_acc_kernel1), 64'hFFFEE);
        chk("basic_k2", 64'(o_acc_kernel2), 64'd900);
        chk("basic_bias", 64'(o_bias), 64'h05);
        idle(2);
        chk("hold_k2", 64'(o_acc_kernel2), 64'd900);

        // gapped input
        cyc(1, 8'h05, 0, 0, 0, 0);
        strobes = 0;
        for (int i = 0; i < 2 * N_TAP; i++) begin
            cyc(0, 0, (i % 2) == 0, 1, -2, 100);
            strobes += int'(o_valid);
        end
        chk("gap_one_strobe", 64'(strobes), 64'd1);
        chk("gap_k1", 64'(o_acc_kernel1), 64'hFFFEE);
        idle(2);

        // ignore rules
        cyc(1, 8'h33, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 7, 7, 7);
        cyc(1, 8'h77, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 7, 7, 7);
        chk("ign_k0", 64'(o_acc_kernel0), 64'd63);
        cyc(0, 0, 1, 500, 500, 500);
        cyc(0, 0, 1, 500, 500, 500);
        chk("ign_idle_k0", 64'(o_acc_kernel0), 64'd63);
        chk("ign_bias", 64'(o_bias), 64'h33);

        // back-to-back windows
        cyc(1, 8'h01, 0, 0, 0, 0);
        for (int i = 0; i < N_TAP; i++) cyc(0, 0, 1, 3, 3, 3);
        chk("b2b_first_valid", 64'(o_valid), 64'd1);
        cyc(1, 8'hFF, 0, 0, 0, 0);
        chk("b2b_busy", 64'(o_busy), 64'd1);
        chk("b2b_clr", 64'(o_acc_kernel0), 64'd0);
        chk("b2b_bias", 64'(o_bias), 64'hFF);
        for (int i = 0; i < N_TAP; i++) cyc(0, 0, 1, 1, 1, 1);
        chk("b2b_second_k0", 64'(o_acc_kernel0), 64'd9);
        idle(1);

        // extremes
        cyc(1, 8'h10, 0, 0, 0, 0);
        for (int i = 0; i < N_TAP; i++) cyc(0, 0, 1, -32768, 32767, -32768);
        chk("ext_neg", 64'(o_acc_kernel0), 64'hB8000);
        chk("ext_pos", 64'(o_acc_kernel1), 64'd294903);
        idle(1);

        // random windows with gaps, stray starts, idle valids and back-to-back starts
        for (int w = 0; w < 30; w++) begin
            cyc(1, int'($urandom_range(255)), $urandom_range(1), rnd_psum(), rnd_psum(), rnd_psum());
            for (int c = 0; c < 60 && m_open; c++)
                cyc($urandom_range(3) == 0, int'($urandom_range(255)), $urandom_range(2) != 0,
                    rnd_psum(), rnd_psum(), rnd_psum());
            chk("rnd_done", 64'(o_valid), 64'(m_present));
            if ($urandom_range(1) == 0)
                cyc(0, 0, $urandom_range(1), rnd_psum(), rnd_psum(), rnd_psum());
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
